hazard_ctrl_param: RTL

//  Parametrised hazard controller for the pipelined datapath. It keeps its own shadow pipeline of
//  in-flight destinations (EX onward) and detects RAW hazards against ID-stage sources.
//  It drives PC/IF-ID stall, ID/EX bubble and per-register flush, runs a RUN/STALL/FLUSH FSM,
//  and watches for runaway stalls.

---
 rtl/hazard_pkg.sv | 40 ++++
 rtl/hazard_shadow_pipe.sv | 57 +++++
 rtl/hazard_ctrl_param.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_pkg                                                   |
// | Description : Shared types for the hazard controller: FSM state encoding,  |
// |               shadow-pipeline entry layout, register-zero constant and the |
// |               source/destination match helper.                             |
// | Config      : none (HAZARD_FWD_EN is consumed by hazard_ctrl_param)        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package hazard_pkg;

  // Widest register address a shadow entry can hold. Narrower REG_AW values
  // are zero-extended into this field by the top level.
  localparam int MAX_AW = 8;

  localparam logic [MAX_AW-1:0] REG0 = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } fsm_state_e;

  typedef struct packed {
    logic              valid;
    logic [MAX_AW-1:0] dest;
    logic              wr;
    logic              load;
  } shadow_entry_t;

  // A source conflicts with an in-flight entry when it is actually read, is
  // not r0, and the entry is a live register write to the same address.
  function automatic logic src_match(input logic used,
                                     input logic [MAX_AW-1:0] addr,
                                     input shadow_entry_t e);
    return used && (addr != REG0) && e.valid && e.wr && (e.dest == addr);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_shadow_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_shadow_pipe                                           |
// | Description : Shift register of in-flight destinations, one entry per      |
// |               pipeline stage after ID (idx 0 = EX). Entry 0 is loaded from |
// |               i_ins every cycle; i_kill invalidates the freshly shifted    |
// |               entries 0..KILL_HI; i_hold freezes the whole pipe.           |
// | Ports       : clk, rst_n (sync, active-low), i_hold, i_ins, i_kill,        |
// |               o_entry[PIPE_DEPTH]                                          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module hazard_shadow_pipe
  import hazard_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int KILL_HI    = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_hold,
  input  shadow_entry_t                   i_ins,
  input  logic                            i_kill,
  output shadow_entry_t [PIPE_DEPTH-1:0]  o_entry
);

  shadow_entry_t [PIPE_DEPTH-1:0] entry_d;
  shadow_entry_t [PIPE_DEPTH-1:0] entry_q;

  always_comb begin
    entry_d = entry_q;
    if (!i_hold) begin
      entry_d[0] = i_ins;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        entry_d[k] = entry_q[k-1];
      end
      // Kill applies to the post-shift positions, i.e. everything younger
      // than the stage that resolved the branch.
      if (i_kill) begin
        for (int k = 0; k <= KILL_HI; k++) begin
          entry_d[k].valid = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign o_entry = entry_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_ctrl_param                                            |
// | Description : Parametrised RAW hazard controller. Tracks in-flight         |
// |               destinations in a shadow pipe, stalls PC/IF-ID and bubbles   |
// |               ID/EX on a conflict, flushes on taken branch or jump, runs a |
// |               RUN/STALL/FLUSH FSM and flags runaway stalls.                |
// | Config      : `HAZARD_FWD_EN  defined   -> only load-use against EX stalls |
// |                               undefined -> any match in idx 0..DEPTH-2    |
// | Ports       : clk, rst_n (sync, active-low)                                |
// |               in : id_valid, id_rs, id_rt, id_rs_used, id_rt_used,         |
// |                    id_dest, id_regwrite, id_memread, id_jump, br_taken     |
// |               out: stall_pc, stall_ifid, bubble_idex,                      |
// |                    flush[BR_STAGE+1:0], stall_cnt[STALL_CW-1:0],           |
// |                    hazard_err                                              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module hazard_ctrl_param
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,   // must not exceed MAX_AW
  parameter int PIPE_DEPTH = 3,
  parameter int BR_STAGE   = 1,   // must be < PIPE_DEPTH
  parameter int MAX_STALL  = 15,
  parameter int STALL_CW   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [REG_AW-1:0]    id_rs,
  input  logic [REG_AW-1:0]    id_rt,
  input  logic                 id_rs_used,
  input  logic                 id_rt_used,
  input  logic [REG_AW-1:0]    id_dest,
  input  logic                 id_regwrite,
  input  logic                 id_memread,
  input  logic                 id_jump,
  input  logic                 br_taken,
  output logic                 stall_pc,
  output logic                 stall_ifid,
  output logic                 bubble_idex,
  output logic [BR_STAGE+1:0]  flush,
  output logic [STALL_CW-1:0]  stall_cnt,
  output logic                 hazard_err
);

  localparam int FLUSH_W = BR_STAGE + 2;

  fsm_state_e            state_d,      state_q;
  logic [STALL_CW-1:0]   stall_cnt_d,  stall_cnt_q;
  logic                  hazard_err_d, hazard_err_q;

  shadow_entry_t [PIPE_DEPTH-1:0] w_entry;
  shadow_entry_t                  w_ins;
  logic [MAX_AW-1:0]              w_rs, w_rt, w_dest;
  logic                           w_in_flush;
  logic                           w_match;
  logic                           w_hz;
  logic                           w_stall;
  logic [FLUSH_W-1:0]             w_flush;
  logic                           w_pipe_hold;
  logic                           w_unused_entry;

  // Debug freeze of the shadow pipe; tied off in the datapath.
  assign w_pipe_hold = 1'b0;

  assign w_rs   = MAX_AW'(id_rs);
  assign w_rt   = MAX_AW'(id_rt);
  assign w_dest = MAX_AW'(id_dest);

  assign w_in_flush = (state_q == FLUSH);

  always_comb begin
    w_match = 1'b0;
`ifdef HAZARD_FWD_EN
    // Forwarding covers everything except a load still in EX.
    w_match = w_entry[0].load &&
              (src_match(id_rs_used, w_rs, w_entry[0]) ||
               src_match(id_rt_used, w_rt, w_entry[0]));
`else
    // The oldest (WB) entry is excluded: the register file writes first.
    for (int k = 0; k < PIPE_DEPTH-1; k++) begin
      w_match = w_match ||
                src_match(id_rs_used, w_rs, w_entry[k]) ||
                src_match(id_rt_used, w_rt, w_entry[k]);
    end
`endif
  end

  // In FLUSH the ID slot holds a killed instruction, so it can never stall.
  assign w_hz    = id_valid && !w_in_flush && w_match;
  assign w_stall = w_hz && !br_taken;

  always_comb begin
    w_flush = '0;
    if (br_taken) begin
      w_flush = '1;
    end else if (id_jump && !w_in_flush && !w_hz) begin
      // A stalled jump waits; it flushes IF/ID in its release cycle.
      w_flush = FLUSH_W'(1);
    end
  end

  assign w_ins = '{valid: id_valid && !w_hz && !w_in_flush && !br_taken,
                   dest:  w_dest,
                   wr:    id_regwrite,
                   load:  id_memread};

  hazard_shadow_pipe #(
    .PIPE_DEPTH (PIPE_DEPTH),
    .KILL_HI    (BR_STAGE)
  ) u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_hold  (w_pipe_hold),
    .i_ins   (w_ins),
    .i_kill  (br_taken),
    .o_entry (w_entry)
  );

  // Not every entry field is consulted in every build.
  assign w_unused_entry = ^w_entry;

  always_comb begin
    state_d = state_q;
    if (br_taken) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        RUN:     if (w_hz)  state_d = STALL;
        STALL:   if (!w_hz) state_d = RUN;
        FLUSH:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end

    stall_cnt_d = '0;
    if (w_stall) begin
      stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + 1'b1;
    end

    hazard_err_d = hazard_err_q ||
                   (w_stall && (int'(stall_cnt_d) >= MAX_STALL));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      stall_cnt_q  <= '0;
      hazard_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      stall_cnt_q  <= stall_cnt_d;
      hazard_err_q <= hazard_err_d;
    end
  end

  // Pipeline control is suppressed while reset is held.
  assign stall_pc    = rst_n && w_stall;
  assign stall_ifid  = rst_n && w_stall;
  assign bubble_idex = rst_n && w_stall;
  assign flush       = rst_n ? w_flush : '0;
  assign stall_cnt   = stall_cnt_q;
  assign hazard_err  = hazard_err_q;

endmodule
`default_nettype wire
